// File: rtl/encrypt_scheduler.sv
// Transaction sequencer for a shared four-function encrypt engine.
// Optional watchdog abort on a stalled engine is enabled by defining ENC_TIMEOUT_EN.
module encrypt_scheduler #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [79:0] in_data,
  input  logic [5:0]  rand6,
  input  logic [8:0]  rand9,
  input  logic [3:0]  fn_mask,
  output logic        eng_start,
  output logic [1:0]  eng_sel,
  output logic [79:0] eng_data,
  output logic [5:0]  eng_rand6,
  output logic [8:0]  eng_rand9,
  input  logic        eng_done,
  input  logic [95:0] eng_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [95:0] out_data,
  output logic [1:0]  out_fn,
  output logic        busy,
  output logic        err_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_HOLD} state_t;

  state_t      state_reg, state_next;
  logic        in_ready_reg;
  logic [1:0]  eng_sel_reg;
  logic [79:0] eng_data_reg;
  logic [5:0]  eng_rand6_reg;
  logic [8:0]  eng_rand9_reg;
  logic        out_valid_reg;
  logic [95:0] out_data_reg;
  logic [1:0]  out_fn_reg;

  logic        accept;
  logic        done_hit;
  logic        timeout_hit;
  logic        out_hs;
  logic [1:0]  raw_sel;
  logic [1:0]  sel_next;

  generate
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << CNT_W) - 1) begin : g_bad_cfg
      $error("encrypt_scheduler: CNT_W too narrow for TIMEOUT_CYCLES");
    end
  endgenerate

  assign accept   = in_valid && in_ready_reg && (state_reg == S_IDLE);
  assign done_hit = (state_reg == S_WAIT) && eng_done;
  assign out_hs   = (state_reg == S_HOLD) && out_ready;

  // Preferred function comes from the random bits; disabled functions are
  // skipped by walking upward modulo 4. An empty mask falls back to FN0.
  always_comb begin
    logic       found;
    logic [1:0] cand;
    raw_sel  = rand6[1:0] ^ rand9[8:7];
    sel_next = 2'd0;
    found    = 1'b0;
    cand     = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = raw_sel + 2'(k);
      if (!found && fn_mask[cand]) begin
        sel_next = cand;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept) state_next = S_START;
      S_START: state_next = S_WAIT;
      S_WAIT:  if (done_hit || timeout_hit) state_next = S_HOLD;
      S_HOLD:  if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // in_ready is registered so it stays low throughout reset and rises on
  // the first edge after release.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg     <= S_IDLE;
      in_ready_reg  <= 1'b0;
      eng_sel_reg   <= 2'd0;
      eng_data_reg  <= 80'd0;
      eng_rand6_reg <= 6'd0;
      eng_rand9_reg <= 9'd0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= 96'd0;
      out_fn_reg    <= 2'd0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next == S_IDLE);
      if (accept) begin
        eng_data_reg  <= in_data;
        eng_rand6_reg <= rand6;
        eng_rand9_reg <= rand9;
        eng_sel_reg   <= sel_next;
      end
      if (done_hit) begin
        out_data_reg  <= eng_result;
        out_fn_reg    <= eng_sel_reg;
        out_valid_reg <= 1'b1;
      end else if (timeout_hit) begin
        out_data_reg  <= 96'd0;
        out_fn_reg    <= eng_sel_reg;
        out_valid_reg <= 1'b1;
      end else if (out_hs) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

`ifdef ENC_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_reg;
  logic             err_timeout_reg;

  // Counter value k means k+1 WAIT cycles have elapsed in the current cycle.
  assign timeout_hit = (state_reg == S_WAIT) && !eng_done &&
                       (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_reg         <= '0;
      err_timeout_reg <= 1'b0;
    end else begin
      if (state_reg == S_START) begin
        cnt_reg <= '0;
      end else if (state_reg == S_WAIT) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (timeout_hit) begin
        err_timeout_reg <= 1'b1;
      end else if (done_hit || out_hs) begin
        err_timeout_reg <= 1'b0;
      end
    end
  end

  assign err_timeout = err_timeout_reg;
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign in_ready  = in_ready_reg;
  assign eng_start = (state_reg == S_START);
  assign eng_sel   = eng_sel_reg;
  assign eng_data  = eng_data_reg;
  assign eng_rand6 = eng_rand6_reg;
  assign eng_rand9 = eng_rand9_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_fn    = out_fn_reg;
  assign busy      = (state_reg != S_IDLE);

endmodule
